// File: rtl/axis_pkg.sv
// Shared definitions for the AXI-Stream word packer: FSM state encoding
// and the lane-ratio helpers used to size and validate the packer.
package axis_pkg;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    HOLD  = 2'd1
  } pack_state_e;

  function automatic int keep_width(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int lane_ratio(input int out_keep_w, input int in_keep_w);
    return out_keep_w / in_keep_w;
  endfunction

  // Elaboration-time check: wide word must hold an integer number (2..256) of narrow beats.
  function automatic bit ratio_ok(input int out_keep_w, input int in_keep_w);
    return (in_keep_w > 0) && (out_keep_w % in_keep_w == 0) &&
           (out_keep_w / in_keep_w >= 2) && (out_keep_w / in_keep_w <= 256);
  endfunction

endpackage

// File: rtl/axis_out_reg.sv
// Single-entry registered AXI-Stream output stage with a "free" indication.
// tuser storage exists only when AXIS_PACKER_TUSER_EN is defined.
module axis_out_reg #(
  parameter int DATA_W = 64,
  parameter int KEEP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [DATA_W-1:0] tdata_i,
  input  logic [KEEP_W-1:0] tkeep_i,
  input  logic              tlast_i,
  input  logic              tuser_i,
  input  logic              tready_i,
  output logic [DATA_W-1:0] tdata_o,
  output logic [KEEP_W-1:0] tkeep_o,
  output logic              tvalid_o,
  output logic              tlast_o,
  output logic              tuser_o,
  output logic              free_o
);

  logic [DATA_W-1:0] tdata_q;
  logic [KEEP_W-1:0] tkeep_q;
  logic              tvalid_q;
  logic              tlast_q;

  assign free_o = !tvalid_q || tready_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      tdata_q  <= '0;
      tkeep_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
    end else if (load_i) begin
      tdata_q  <= tdata_i;
      tkeep_q  <= tkeep_i;
      tvalid_q <= 1'b1;
      tlast_q  <= tlast_i;
    end else if (tready_i) begin
      tvalid_q <= 1'b0;
    end
  end

`ifdef AXIS_PACKER_TUSER_EN
  logic tuser_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tuser_q <= 1'b0;
    end else if (load_i) begin
      tuser_q <= tuser_i;
    end
  end

  assign tuser_o = tuser_q;
`else
  logic unused_tuser_i;
  assign unused_tuser_i = tuser_i;
  assign tuser_o        = 1'b0;
`endif

  assign tdata_o  = tdata_q;
  assign tkeep_o  = tkeep_q;
  assign tvalid_o = tvalid_q;
  assign tlast_o  = tlast_q;

endmodule

// File: rtl/axis_word_packer.sv
// Narrow-to-wide AXI-Stream packer: beat k of a word lands in lane k, tlast ends a word early.
// tuser accumulation is enabled by defining AXIS_PACKER_TUSER_EN.
//
// state | meaning
// ACCUM | accepting beats into the accumulator (tready high)
// HOLD  | completed word parked in the accumulator, waiting for the output register
module axis_word_packer
  import axis_pkg::*;
#(
  parameter int INPUT_DATA_WIDTH  = 8,
  parameter int INPUT_KEEP_WIDTH  = keep_width(INPUT_DATA_WIDTH),
  parameter int OUTPUT_DATA_WIDTH = 64,
  parameter int OUTPUT_KEEP_WIDTH = keep_width(OUTPUT_DATA_WIDTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [INPUT_DATA_WIDTH-1:0]  input_axis_tdata,
  input  logic [INPUT_KEEP_WIDTH-1:0]  input_axis_tkeep,
  input  logic                         input_axis_tvalid,
  output logic                         input_axis_tready,
  input  logic                         input_axis_tlast,
  input  logic                         input_axis_tuser,
  output logic [OUTPUT_DATA_WIDTH-1:0] output_axis_tdata,
  output logic [OUTPUT_KEEP_WIDTH-1:0] output_axis_tkeep,
  output logic                         output_axis_tvalid,
  input  logic                         output_axis_tready,
  output logic                         output_axis_tlast,
  output logic                         output_axis_tuser
);

  localparam int N  = lane_ratio(OUTPUT_KEEP_WIDTH, INPUT_KEEP_WIDTH);
  localparam int IW = INPUT_DATA_WIDTH;
  localparam int IK = INPUT_KEEP_WIDTH;
  localparam logic [7:0] LAST_LANE = 8'(N - 1);

  if (!ratio_ok(OUTPUT_KEEP_WIDTH, INPUT_KEEP_WIDTH)) begin : g_ratio_check
    $error("axis_word_packer: output/input keep ratio must be an integer in 2..256");
  end

  pack_state_e state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        tready_q, tready_d;
  logic [OUTPUT_DATA_WIDTH-1:0] acc_data_q, mrg_data, ld_data;
  logic [OUTPUT_KEEP_WIDTH-1:0] acc_keep_q, mrg_keep, ld_keep;
  logic        acc_last_q, ld_last, ld_user;
  logic        accept, complete, out_free, load, acc_upd, acc_clr;

  assign accept            = input_axis_tvalid && tready_q;
  assign complete          = accept && (input_axis_tlast || cnt_q == LAST_LANE);
  assign input_axis_tready = tready_q;

  // Current beat merged into its lane; lanes above it are still zero from the last clear.
  always_comb begin
    mrg_data = acc_data_q;
    mrg_keep = acc_keep_q;
    for (int k = 0; k < N; k++) begin
      if (cnt_q == 8'(k)) begin
        mrg_data[k*IW +: IW] = input_axis_tdata;
        mrg_keep[k*IK +: IK] = input_axis_tkeep;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tready_d = tready_q;
    acc_upd  = 1'b0;
    acc_clr  = 1'b0;
    load     = 1'b0;
    unique case (state_q)
      ACCUM: begin
        tready_d = 1'b1;
        if (accept) begin
          if (complete) begin
            cnt_d = '0;
            if (out_free) begin
              load    = 1'b1;
              acc_clr = 1'b1;
            end else begin
              acc_upd  = 1'b1;
              state_d  = HOLD;
              tready_d = 1'b0;
            end
          end else begin
            cnt_d   = cnt_q + 8'd1;
            acc_upd = 1'b1;
          end
        end
      end
      HOLD: begin
        tready_d = 1'b0;
        if (out_free) begin
          load     = 1'b1;
          acc_clr  = 1'b1;
          state_d  = ACCUM;
          tready_d = 1'b1;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ACCUM;
      cnt_q      <= '0;
      tready_q   <= 1'b0;
      acc_data_q <= '0;
      acc_keep_q <= '0;
      acc_last_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tready_q <= tready_d;
      if (acc_clr) begin
        acc_data_q <= '0;
        acc_keep_q <= '0;
        acc_last_q <= 1'b0;
      end else if (acc_upd) begin
        acc_data_q <= mrg_data;
        acc_keep_q <= mrg_keep;
        acc_last_q <= input_axis_tlast;
      end
    end
  end

  assign ld_data = (state_q == HOLD) ? acc_data_q : mrg_data;
  assign ld_keep = (state_q == HOLD) ? acc_keep_q : mrg_keep;
  assign ld_last = (state_q == HOLD) ? acc_last_q : input_axis_tlast;

`ifdef AXIS_PACKER_TUSER_EN
  logic acc_user_q;

  always_ff @(posedge clk) begin
    if (rst || acc_clr) begin
      acc_user_q <= 1'b0;
    end else if (acc_upd) begin
      acc_user_q <= acc_user_q | input_axis_tuser;
    end
  end

  assign ld_user = (state_q == HOLD) ? acc_user_q : (acc_user_q | input_axis_tuser);
`else
  logic unused_tuser;
  assign unused_tuser = input_axis_tuser;
  assign ld_user      = 1'b0;
`endif

  axis_out_reg #(
    .DATA_W (OUTPUT_DATA_WIDTH),
    .KEEP_W (OUTPUT_KEEP_WIDTH)
  ) u_out_reg (
    .clk      (clk),
    .rst      (rst),
    .load_i   (load),
    .tdata_i  (ld_data),
    .tkeep_i  (ld_keep),
    .tlast_i  (ld_last),
    .tuser_i  (ld_user),
    .tready_i (output_axis_tready),
    .tdata_o  (output_axis_tdata),
    .tkeep_o  (output_axis_tkeep),
    .tvalid_o (output_axis_tvalid),
    .tlast_o  (output_axis_tlast),
    .tuser_o  (output_axis_tuser),
    .free_o   (out_free)
  );

endmodule

// File: tb/tb_axis_word_packer.sv
// Scoreboard bench for axis_word_packer (8-bit in, 64-bit out): directed cases plus random frames.
`timescale 1ns/1ps
module tb_axis_word_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_data = '0;
  logic [0:0]  in_keep = '0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_user = 1'b0;
  logic        in_ready;
  logic [63:0] out_data;
  logic [7:0]  out_keep;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_last;
  logic        out_user;

  axis_word_packer dut (
    .clk                (clk),
    .rst                (rst),
    .input_axis_tdata   (in_data),
    .input_axis_tkeep   (in_keep),
    .input_axis_tvalid  (in_valid),
    .input_axis_tready  (in_ready),
    .input_axis_tlast   (in_last),
    .input_axis_tuser   (in_user),
    .output_axis_tdata  (out_data),
    .output_axis_tkeep  (out_keep),
    .output_axis_tvalid (out_valid),
    .output_axis_tready (out_ready),
    .output_axis_tlast  (out_last),
    .output_axis_tuser  (out_user)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic        user;
  } word_t;

  word_t exp_q[$];
  int    n_vec = 0;
  int    n_err = 0;
  bit    rand_ready = 1'b0;
  bit    forced_ready = 1'b1;

  logic [7:0] fd[32];
  logic       fk[32];
  logic       fu[32];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: cut the frame into 8-byte chunks, byte j of a chunk goes to bits [8j+7:8j].
  task automatic model_push(input int len);
    for (int s = 0; s < len; s += 8) begin
      word_t w;
      int    n;
      n = (len - s < 8) ? len - s : 8;
      w = '0;
      for (int j = 0; j < n; j++) begin
        w.data = w.data | (64'(fd[s+j]) << (8 * j));
        w.keep[j] = fk[s+j];
        w.user = w.user | fu[s+j];
      end
      w.last = (s + n == len);
`ifndef AXIS_PACKER_TUSER_EN
      w.user = 1'b0;
`endif
      exp_q.push_back(w);
    end
  endtask

  // Called at a negedge; returns at the negedge after the beat was accepted.
  task automatic send_frame(input int len, input bit last_end, input bit push, input bit gaps);
    if (push) model_push(len);
    for (int i = 0; i < len; i++) begin
      bit ok;
      int g;
      g = 0;
      while (gaps && g < 4 && $urandom_range(1, 0) == 1) begin
        in_valid = 1'b0;
        @(negedge clk);
        g++;
      end
      in_valid = 1'b1;
      in_data  = fd[i];
      in_keep  = fk[i];
      in_user  = fu[i];
      in_last  = last_end && (i == len - 1);
      ok = 1'b0;
      for (int t = 0; t < 200 && !ok; t++) begin
        ok = in_ready;
        @(negedge clk);
      end
      if (!ok) begin
        n_vec++;
        n_err++;
        $display("FAIL accept_timeout: got no tready expected accept within 200 cycles");
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_user  = 1'b0;
  endtask

  task automatic fill_seq(input int len, input logic [7:0] base);
    for (int i = 0; i < 32; i++) begin
      fd[i] = (i < len) ? base + 8'(i) : 8'h00;
      fk[i] = 1'b1;
      fu[i] = 1'b0;
    end
  endtask

  // Monitor: picks out_ready each negedge and checks any transfer that the next posedge will make.
  initial begin
    word_t w;
    forever begin
      @(negedge clk);
      out_ready = rand_ready ? 1'($urandom_range(1, 0)) : forced_ready;
      if (out_valid && out_ready && !rst) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_word: got %h expected no output", out_data);
        end else begin
          w = exp_q.pop_front();
          chk("sb_tdata", out_data, w.data);
          chk("sb_tkeep", 64'(out_keep), 64'(w.keep));
          chk("sb_tlast", 64'(out_last), 64'(w.last));
          chk("sb_tuser", 64'(out_user), 64'(w.user));
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tvalid", 64'(out_valid), 64'd0);
    chk("rst_tdata", out_data, 64'd0);
    chk("rst_tkeep", 64'(out_keep), 64'd0);
    chk("rst_tready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("tready_after_rst", 64'(in_ready), 64'd1);

    // Full 8-byte frame, tlast on the 8th beat
    fill_seq(8, 8'h01);
    send_frame(8, 1'b1, 1'b1, 1'b0);
    chk("full_latency_valid", 64'(out_valid), 64'd1);
    chk("full_tdata", out_data, 64'h0807060504030201);
    chk("full_tkeep", 64'(out_keep), 64'hFF);
    chk("full_tlast", 64'(out_last), 64'd1);

    // Short frame: 3 bytes
    fill_seq(3, 8'h00);
    fd[0] = 8'hAA; fd[1] = 8'hBB; fd[2] = 8'hCC;
    send_frame(3, 1'b1, 1'b1, 1'b0);
    chk("short_tdata", out_data, 64'h0000000000CCBBAA);
    chk("short_tkeep", 64'(out_keep), 64'h07);

    // Backpressure: second word completes while the first is stalled
    #1 forced_ready = 1'b0;
    fill_seq(8, 8'h11);
    send_frame(8, 1'b1, 1'b1, 1'b0);
    fill_seq(8, 8'h21);
    send_frame(8, 1'b1, 1'b1, 1'b0);
    chk("hold_tready_low", 64'(in_ready), 64'd0);
    chk("hold_first_word", out_data, 64'h1817161514131211);
    repeat (2) @(negedge clk);
    chk("hold_first_stable", out_data, 64'h1817161514131211);
    chk("hold_valid_stable", 64'(out_valid), 64'd1);
    #1 forced_ready = 1'b1;
    @(negedge clk);
    chk("bubble_tready_low", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk("bubble_tready_high", 64'(in_ready), 64'd1);
    chk("second_word_out", out_data, 64'h2827262524232221);

    // tuser on beat 4 of the first word only
    fill_seq(16, 8'h40);
    fu[3] = 1'b1;
    send_frame(16, 1'b1, 1'b1, 1'b0);
    repeat (2) @(negedge clk);

    // Reset after 5 beats of a frame: partial word must vanish
    fill_seq(5, 8'h60);
    send_frame(5, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_tvalid", 64'(out_valid), 64'd0);
    chk("midrst_tdata", out_data, 64'd0);
    chk("midrst_tready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    fill_seq(8, 8'h71);
    send_frame(8, 1'b1, 1'b1, 1'b0);
    chk("post_rst_tdata", out_data, 64'h7877767574737271);
    @(negedge clk);

    // Random frames with input gaps and random downstream ready
    rand_ready = 1'b1;
    for (int f = 0; f < 100; f++) begin
      int len;
      len = $urandom_range(20, 1);
      for (int i = 0; i < 32; i++) begin
        fd[i] = 8'($urandom);
        fk[i] = ($urandom_range(9, 0) != 0);
        fu[i] = ($urandom_range(9, 0) == 0);
      end
      send_frame(len, 1'b1, 1'b1, 1'b1);
    end

    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
